// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and tag-compare helper for the hazard controller.
// Writeback-select and forwarding-select encodings live here so the datapath agrees with them.
package hazard_ctrl_pkg;

    localparam logic [1:0] DM2REG_MEM = 2'b01;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic tag_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-tag inputs and hazard-control outputs between the datapath (master) and the
// hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs_d;
    logic [4:0]       rt_d;
    logic             branch_d;
    logic             jr_d;
    logic             hilo_use_d;
    logic [4:0]       rs_e;
    logic [4:0]       rt_e;
    logic [4:0]       rf_wae;
    logic             we_rege;
    logic [1:0]       dm2rege;
    logic             hilo_wee;
    logic [4:0]       rf_wam;
    logic             we_regm;
    logic [1:0]       dm2regm;
    logic [4:0]       rf_waw;
    logic             we_regw;
    logic             perf_clr;

    logic             stall_f;
    logic             stall_d;
    logic             flush_e;
    logic             forward_ad;
    logic             forward_bd;
    logic [1:0]       forward_ae;
    logic [1:0]       forward_be;
    logic             hilo_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output rs_d, rt_d, branch_d, jr_d, hilo_use_d,
        output rs_e, rt_e, rf_wae, we_rege, dm2rege, hilo_wee,
        output rf_wam, we_regm, dm2regm, rf_waw, we_regw, perf_clr,
        input  stall_f, stall_d, flush_e, forward_ad, forward_bd,
        input  forward_ae, forward_be, hilo_busy, stall_cycles
    );

    modport slave (
        input  rs_d, rt_d, branch_d, jr_d, hilo_use_d,
        input  rs_e, rt_e, rf_wae, we_rege, dm2rege, hilo_wee,
        input  rf_wam, we_regm, dm2regm, rf_waw, we_regw, perf_clr,
        output stall_f, stall_d, flush_e, forward_ad, forward_bd,
        output forward_ae, forward_be, hilo_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Execute-stage operand forwarding select for one source tag.
// A match in M wins over W because M holds the younger result.
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       we_m_i,
    input  logic [4:0] wa_m_i,
    input  logic       we_w_i,
    input  logic [4:0] wa_w_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (we_m_i && tag_hit(src_i, wa_m_i)) begin
            sel_o = FWD_MEM;
        end else if (we_w_i && tag_hit(src_i, wa_w_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use/branch/HI-LO stalls, the HI/LO busy window
// and a saturating count of stalled cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    localparam int unsigned      BusyW    = $clog2(MULDIV_LAT + 1);
    localparam logic [BusyW-1:0] BusyLoad = BusyW'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    logic             load_e;
    logic             load_m;
    logic             br_src_e;
    logic             br_src_m;
    logic             lw_stall;
    logic             br_stall;
    logic             hilo_stall;
    logic             stall;
    logic [BusyW-1:0] busy_d;
    logic [BusyW-1:0] busy_q;
    logic [CNT_W-1:0] stall_cycles_d;
    logic [CNT_W-1:0] stall_cycles_q;

    hazard_ctrl_fwd_sel u_fwd_a (
        .src_i  (hz.rs_e),
        .we_m_i (hz.we_regm),
        .wa_m_i (hz.rf_wam),
        .we_w_i (hz.we_regw),
        .wa_w_i (hz.rf_waw),
        .sel_o  (hz.forward_ae)
    );

    hazard_ctrl_fwd_sel u_fwd_b (
        .src_i  (hz.rt_e),
        .we_m_i (hz.we_regm),
        .wa_m_i (hz.rf_wam),
        .we_w_i (hz.we_regw),
        .wa_w_i (hz.rf_waw),
        .sel_o  (hz.forward_be)
    );

    always_comb begin
        load_e = (hz.dm2rege == DM2REG_MEM);
        load_m = (hz.dm2regm == DM2REG_MEM);

        // Decode-stage compare only has alu_outm available; a load in M is not ready yet.
        hz.forward_ad = hz.we_regm && !load_m && tag_hit(hz.rs_d, hz.rf_wam);
        hz.forward_bd = hz.we_regm && !load_m && tag_hit(hz.rt_d, hz.rf_wam);

        lw_stall = load_e && hz.we_rege &&
                   (tag_hit(hz.rs_d, hz.rf_wae) || tag_hit(hz.rt_d, hz.rf_wae));

        // jr reads only rs; beq reads both operands.
        br_src_e = tag_hit(hz.rs_d, hz.rf_wae) || (hz.branch_d && tag_hit(hz.rt_d, hz.rf_wae));
        br_src_m = tag_hit(hz.rs_d, hz.rf_wam) || (hz.branch_d && tag_hit(hz.rt_d, hz.rf_wam));
        br_stall = (hz.branch_d || hz.jr_d) &&
                   ((hz.we_rege && br_src_e) || (load_m && br_src_m));

        hilo_stall = hz.hilo_use_d && (hz.hilo_wee || (busy_q != '0));

        stall      = lw_stall || br_stall || hilo_stall;
        hz.stall_f = stall;
        hz.stall_d = stall;
        hz.flush_e = stall;

        hz.hilo_busy    = (busy_q != '0);
        hz.stall_cycles = stall_cycles_q;
    end

    always_comb begin
        busy_d = busy_q;
        // A new op in E restarts the window even if the previous one is still counting.
        if (hz.hilo_wee) begin
            busy_d = BusyLoad;
        end else if (busy_q != '0) begin
            busy_d = busy_q - BusyW'(1);
        end

        stall_cycles_d = stall_cycles_q;
        if (hz.perf_clr) begin
            stall_cycles_d = '0;
        end else if (stall && (stall_cycles_q != CntMax)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            stall_cycles_q <= '0;
        end else begin
            busy_q         <= busy_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: forwarding priority, load-use and branch stalls,
// HI/LO busy window with async reset, and the saturating stall counter (CNT_W=4).
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    hazard_ctrl_if #(.CNT_W(4)) hz ();

    hazard_ctrl #(
        .MULDIV_LAT (4),
        .CNT_W      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.rs_d = 5'd0; hz.rt_d = 5'd0; hz.branch_d = 1'b0; hz.jr_d = 1'b0;
        hz.hilo_use_d = 1'b0; hz.rs_e = 5'd0; hz.rt_e = 5'd0; hz.rf_wae = 5'd0;
        hz.we_rege = 1'b0; hz.dm2rege = 2'b00; hz.hilo_wee = 1'b0; hz.rf_wam = 5'd0;
        hz.we_regm = 1'b0; hz.dm2regm = 2'b00; hz.rf_waw = 5'd0; hz.we_regw = 1'b0;
        hz.perf_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        checks++;
        if (hz.hilo_busy !== 1'b0 || hz.stall_cycles !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b cnt=%0d, want busy=0 cnt=0",
                     hz.hilo_busy, hz.stall_cycles);
        end
        checks++;
        if (hz.stall_d !== 1'b0 || hz.forward_ae !== 2'b00 || hz.forward_ad !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: stall_d=%b fwd_ae=%b fwd_ad=%b, want 0 00 0",
                     hz.stall_d, hz.forward_ae, hz.forward_ad);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_forward();
        idle();
        hz.rs_e = 5'd5; hz.rf_wam = 5'd5; hz.we_regm = 1'b1; hz.rf_waw = 5'd5; hz.we_regw = 1'b1;
        #1;
        checks++;
        if (hz.forward_ae !== 2'b10) begin
            errors++;
            $display("FAIL fwd_m_prio: forward_ae=%b want 10", hz.forward_ae);
        end
        hz.we_regm = 1'b0;
        #1;
        checks++;
        if (hz.forward_ae !== 2'b01) begin
            errors++;
            $display("FAIL fwd_w: forward_ae=%b want 01", hz.forward_ae);
        end
        hz.rs_e = 5'd0; hz.rf_wam = 5'd0; hz.rf_waw = 5'd0; hz.we_regm = 1'b1;
        #1;
        checks++;
        if (hz.forward_ae !== 2'b00) begin
            errors++;
            $display("FAIL fwd_r0: forward_ae=%b want 00", hz.forward_ae);
        end
        idle();
        hz.rt_e = 5'd7; hz.rf_waw = 5'd7; hz.we_regw = 1'b1; hz.rf_wam = 5'd9; hz.we_regm = 1'b1;
        #1;
        checks++;
        if (hz.forward_be !== 2'b01 || hz.forward_ae !== 2'b00) begin
            errors++;
            $display("FAIL fwd_be_w: forward_be=%b ae=%b want 01 00", hz.forward_be, hz.forward_ae);
        end
        idle();
        hz.rs_d = 5'd4; hz.rt_d = 5'd4; hz.rf_wam = 5'd4; hz.we_regm = 1'b1; hz.dm2regm = 2'b00;
        #1;
        checks++;
        if (hz.forward_ad !== 1'b1 || hz.forward_bd !== 1'b1 || hz.stall_d !== 1'b0) begin
            errors++;
            $display("FAIL fwd_d_alu: ad=%b bd=%b stall=%b want 1 1 0",
                     hz.forward_ad, hz.forward_bd, hz.stall_d);
        end
        hz.dm2regm = 2'b01;
        #1;
        checks++;
        if (hz.forward_ad !== 1'b0 || hz.forward_bd !== 1'b0) begin
            errors++;
            $display("FAIL fwd_d_load: ad=%b bd=%b want 0 0", hz.forward_ad, hz.forward_bd);
        end
        step();
    endtask

    task automatic test_load_use();
        idle();
        hz.dm2rege = 2'b01; hz.we_rege = 1'b1; hz.rf_wae = 5'd8; hz.rt_d = 5'd8;
        #1;
        checks++;
        if (hz.stall_d !== 1'b1 || hz.stall_f !== 1'b1 || hz.flush_e !== 1'b1) begin
            errors++;
            $display("FAIL lw_stall: stall_d=%b stall_f=%b flush_e=%b want 111",
                     hz.stall_d, hz.stall_f, hz.flush_e);
        end
        step();
        hz.rf_wae = 5'd9;
        #1;
        checks++;
        if (hz.stall_d !== 1'b0 || hz.flush_e !== 1'b0) begin
            errors++;
            $display("FAIL lw_nohit: stall_d=%b flush_e=%b want 0 0", hz.stall_d, hz.flush_e);
        end
        hz.rf_wae = 5'd0; hz.rt_d = 5'd0;
        #1;
        checks++;
        if (hz.stall_d !== 1'b0) begin
            errors++;
            $display("FAIL lw_r0: stall_d=%b want 0", hz.stall_d);
        end
        step();
    endtask

    task automatic test_branch();
        idle();
        hz.branch_d = 1'b1; hz.rs_d = 5'd3; hz.we_rege = 1'b1; hz.rf_wae = 5'd3;
        #1;
        checks++;
        if (hz.stall_d !== 1'b1) begin
            errors++;
            $display("FAIL br_e: stall_d=%b want 1", hz.stall_d);
        end
        step();
        hz.we_rege = 1'b0; hz.rf_wae = 5'd0;
        hz.rf_wam = 5'd3; hz.we_regm = 1'b1; hz.dm2regm = 2'b01;
        #1;
        checks++;
        if (hz.stall_d !== 1'b1 || hz.forward_ad !== 1'b0) begin
            errors++;
            $display("FAIL br_load_m: stall_d=%b fwd_ad=%b want 1 0", hz.stall_d, hz.forward_ad);
        end
        step();
        hz.dm2regm = 2'b00;
        #1;
        checks++;
        if (hz.stall_d !== 1'b0 || hz.forward_ad !== 1'b1) begin
            errors++;
            $display("FAIL br_alu_m: stall_d=%b fwd_ad=%b want 0 1", hz.stall_d, hz.forward_ad);
        end
        idle();
        hz.jr_d = 1'b1; hz.rs_d = 5'd3; hz.rt_d = 5'd6; hz.we_rege = 1'b1; hz.rf_wae = 5'd6;
        #1;
        checks++;
        if (hz.stall_d !== 1'b0) begin
            errors++;
            $display("FAIL jr_rt_ignored: stall_d=%b want 0", hz.stall_d);
        end
        hz.rf_wae = 5'd3;
        #1;
        checks++;
        if (hz.stall_d !== 1'b1) begin
            errors++;
            $display("FAIL jr_rs: stall_d=%b want 1", hz.stall_d);
        end
        step();
    endtask

    task automatic test_hilo();
        idle();
        hz.hilo_wee = 1'b1; hz.hilo_use_d = 1'b1;
        #1;
        checks++;
        if (hz.stall_d !== 1'b1 || hz.hilo_busy !== 1'b0) begin
            errors++;
            $display("FAIL hilo_start: stall_d=%b busy=%b want 1 0", hz.stall_d, hz.hilo_busy);
        end
        step();
        hz.hilo_wee = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hz.stall_d !== 1'b1 || hz.hilo_busy !== 1'b1) begin
                errors++;
                $display("FAIL hilo_window[%0d]: stall_d=%b busy=%b want 1 1",
                         i, hz.stall_d, hz.hilo_busy);
            end
            step();
        end
        checks++;
        if (hz.stall_d !== 1'b0 || hz.hilo_busy !== 1'b0) begin
            errors++;
            $display("FAIL hilo_end: stall_d=%b busy=%b want 0 0", hz.stall_d, hz.hilo_busy);
        end
        // Restart: second op one cycle in reloads a full window.
        hz.hilo_wee = 1'b1;
        step();
        step();
        hz.hilo_wee = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hz.hilo_busy !== 1'b1) begin
                errors++;
                $display("FAIL hilo_restart[%0d]: busy=%b want 1", i, hz.hilo_busy);
            end
            step();
        end
        checks++;
        if (hz.hilo_busy !== 1'b0) begin
            errors++;
            $display("FAIL hilo_restart_end: busy=%b want 0", hz.hilo_busy);
        end
        hz.hilo_wee = 1'b1;
        step();
        hz.hilo_wee = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (hz.hilo_busy !== 1'b0 || hz.stall_d !== 1'b0) begin
            errors++;
            $display("FAIL hilo_async_rst: busy=%b stall_d=%b want 0 0", hz.hilo_busy, hz.stall_d);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();
    endtask

    task automatic test_counter();
        idle();
        hz.perf_clr = 1'b1;
        step();
        hz.perf_clr = 1'b0;
        checks++;
        if (hz.stall_cycles !== 4'd0) begin
            errors++;
            $display("FAIL cnt_clr: stall_cycles=%0d want 0", hz.stall_cycles);
        end
        hz.hilo_wee = 1'b1; hz.hilo_use_d = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (hz.stall_cycles !== 4'd10) begin
            errors++;
            $display("FAIL cnt_10: stall_cycles=%0d want 10", hz.stall_cycles);
        end
        hz.perf_clr = 1'b1;
        step();
        hz.perf_clr = 1'b0;
        checks++;
        if (hz.stall_cycles !== 4'd0) begin
            errors++;
            $display("FAIL cnt_clr_prio: stall_cycles=%0d want 0", hz.stall_cycles);
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (hz.stall_cycles !== 4'd15) begin
            errors++;
            $display("FAIL cnt_sat: stall_cycles=%0d want 15", hz.stall_cycles);
        end
        step();
        checks++;
        if (hz.stall_cycles !== 4'd15) begin
            errors++;
            $display("FAIL cnt_nowrap: stall_cycles=%0d want 15", hz.stall_cycles);
        end
        idle();
        for (int i = 0; i < 5; i++) step();
        hz.perf_clr = 1'b1;
        step();
        hz.perf_clr = 1'b0;
        step();
        checks++;
        if (hz.stall_cycles !== 4'd0) begin
            errors++;
            $display("FAIL cnt_idle_hold: stall_cycles=%0d want 0", hz.stall_cycles);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_hilo();
        test_counter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
